// File: rtl/gf180mcu_osu_sc_clk_pkg.sv
// Shared types and helpers for the gf180mcu OSU clock-tree generators.
// Divisor helpers operate on 32 bits; callers cast to their own width.
package gf180mcu_osu_sc_clk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
    endfunction

    // High phase takes the extra cycle of an odd ratio.
    function automatic logic [31:0] high_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_if.sv
// Control and output bundle of the programmable clock divider.
// The master side requests ratio/polarity; the slave side is the divider.
interface gf180mcu_osu_sc_12t_clkdiv_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             INV;
    logic             Y;
    logic             YN;
    logic             EDGE;
    logic             DIV_ACK;
    logic             ACTIVE;

    modport master (
        output EN, DIV, INV,
        input  Y, YN, EDGE, DIV_ACK, ACTIVE
    );

    modport slave (
        input  EN, DIV, INV,
        output Y, YN, EDGE, DIV_ACK, ACTIVE
    );
endinterface

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_cnt.sv
// Period counter: counts 0..div-1 while running, wraps at div-1.
// Exposes the next count so the top can register phase in lock-step.
module gf180mcu_osu_sc_12t_clkdiv_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             boundary
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign boundary = (cnt_q == div - WIDTH'(1));
    assign cnt_nxt  = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkdiv.sv
// Programmable glitch-free clock divider with polarity select.
// Ratio and polarity change only at period boundaries; all outputs registered.
module gf180mcu_osu_sc_12t_clkdiv
    import gf180mcu_osu_sc_clk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    gf180mcu_osu_sc_12t_clkdiv_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             inv_q, inv_d;
    logic             y_q, y_d;
    logic             yn_q, yn_d;
    logic             edge_q, edge_d;
    logic             ack_q, ack_d;
    logic             active_q, active_d;

    logic             load;
    logic             phase;
    logic             boundary;
    logic             cnt_clr;
    logic             cnt_run;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_cl;

    assign div_cl  = WIDTH'(clamp_div(32'(bus.DIV)));
    assign cnt_clr = (state_q == IDLE);
    assign cnt_run = (state_q != IDLE);

    gf180mcu_osu_sc_12t_clkdiv_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (CLK),
        .rst     (RST),
        .clr     (cnt_clr),
        .run     (cnt_run),
        .div     (div_q),
        .cnt_nxt (cnt_nxt),
        .boundary(boundary)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        inv_d   = inv_q;
        load    = 1'b0;
        ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.EN) begin
                    load    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    inv_d = 1'b0;
                end
            end
            RUN, STOP: begin
                if (boundary) begin
                    if (bus.EN) begin
                        load    = 1'b1;
                        ack_d   = (div_cl != div_q) || (bus.INV != inv_q);
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = bus.EN ? RUN : STOP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            div_d = div_cl;
            inv_d = bus.INV;
        end
        // Phase is derived from the post-edge count so Y lands with it.
        phase    = (state_d != IDLE)
                && (32'(cnt_nxt) < high_len(32'(div_d)));
        y_d      = phase ^ inv_d;
        yn_d     = ~y_d;
        edge_d   = load;
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            div_q    <= WIDTH'(RESET_DIV);
            inv_q    <= 1'b0;
            y_q      <= 1'b0;
            yn_q     <= 1'b1;
            edge_q   <= 1'b0;
            ack_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            inv_q    <= inv_d;
            y_q      <= y_d;
            yn_q     <= yn_d;
            edge_q   <= edge_d;
            ack_q    <= ack_d;
            active_q <= active_d;
        end
    end

    assign bus.Y       = y_q;
    assign bus.YN      = yn_q;
    assign bus.EDGE    = edge_q;
    assign bus.DIV_ACK = ack_q;
    assign bus.ACTIVE  = active_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv
// Scoreboard bench for the clock divider: a period-level reference model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_gf180mcu_osu_sc_12t_clkdiv;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    gf180mcu_osu_sc_12t_clkdiv_if #(.WIDTH(W)) bus ();

    gf180mcu_osu_sc_12t_clkdiv #(
        .WIDTH    (W),
        .RESET_DIV(2)
    ) u_dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic y;
        logic yn;
        logic edg;
        logic ack;
        logic act;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: position inside the current period.
    bit m_run;
    int m_pos;
    int m_n;
    bit m_inv;

    function automatic int clampf(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic exp_t cur_exp(input bit ed, input bit ak);
        exp_t e;
        bit   ph;
        ph    = m_run && (m_pos < (m_n - m_n / 2));
        e.y   = m_run ? (ph ^ m_inv) : m_inv;
        e.yn  = ~e.y;
        e.edg = ed;
        e.ack = ak;
        e.act = m_run;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_pos = 0;
        m_n   = 2;
        m_inv = 0;
    endtask

    task automatic model_edge(input bit en, input int div, input bit inv,
                              output bit ed, output bit ak);
        ed = 0;
        ak = 0;
        if (!m_run) begin
            if (en) begin
                m_n   = clampf(div);
                m_inv = inv;
                m_run = 1;
                m_pos = 0;
                ed    = 1;
                ak    = 1;
            end else begin
                m_inv = 0;
            end
        end else if (m_pos == m_n - 1) begin
            if (en) begin
                ak    = (clampf(div) != m_n) || (inv != m_inv);
                m_n   = clampf(div);
                m_inv = inv;
                m_pos = 0;
                ed    = 1;
            end else begin
                m_run = 0;
                m_pos = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    function automatic exp_t rst_exp();
        exp_t e;
        e = '{y: 1'b0, yn: 1'b1, edg: 1'b0, ack: 1'b0, act: 1'b0};
        return e;
    endfunction

    task automatic step(input bit r, input bit en, input int div,
                        input bit inv);
        bit ed, ak;
        @(negedge CLK);
        #1;
        RST     = r;
        bus.EN  = en;
        bus.DIV = W'(div);
        bus.INV = inv;
        @(posedge CLK);
        if (r) begin
            model_reset();
            q.push_back(rst_exp());
        end else begin
            model_edge(en, div, inv, ed, ak);
            q.push_back(cur_exp(ed, ak));
        end
    endtask

    // Reset lands between edges, checked at the following negedge.
    task automatic mid_reset();
        @(negedge CLK);
        #1;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        model_reset();
        q.push_back(rst_exp());
    endtask

    task automatic run_to_pos(input int p, input int div, input bit inv);
        int n;
        n = 0;
        while (!(m_run && m_pos == p) && n < 600) begin
            step(0, 1, div, inv);
            n++;
        end
        if (n >= 600) begin
            failures++;
            $display("FAIL align: pos=%0d required=%0d", m_pos, p);
        end
    endtask

    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge CLK);
            cyc++;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = '{y: bus.Y, yn: bus.YN, edg: bus.EDGE,
                        ack: bus.DIV_ACK, act: bus.ACTIVE};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got{Y,YN,EDGE,ACK,ACT}=%b required=%b",
                             cyc, got, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cdiv;
        bit cinv;
        bus.EN  = 1'b0;
        bus.DIV = '0;
        bus.INV = 1'b0;
        model_reset();
        repeat (3) step(1, 0, 0, 0);

        repeat (16) step(0, 1, 4, 0);

        run_to_pos(0, 5, 0);
        repeat (2) step(0, 1, 5, 0);
        repeat (12) step(0, 1, 3, 0);

        repeat (8) step(0, 1, 0, 0);
        repeat (8) step(0, 1, 1, 0);

        run_to_pos(0, 6, 0);
        run_to_pos(1, 6, 0);
        repeat (10) step(0, 0, 6, 0);
        repeat (2) step(0, 1, 6, 0);
        repeat (2) step(0, 0, 6, 0);
        repeat (12) step(0, 1, 6, 0);

        run_to_pos(1, 4, 0);
        repeat (9) step(0, 1, 4, 1);
        repeat (2) step(0, 0, 4, 1);
        repeat (8) step(0, 0, 4, 1);
        repeat (6) step(0, 1, 4, 0);

        run_to_pos(3, 8, 0);
        mid_reset();
        repeat (2) step(1, 1, 7, 0);
        repeat (10) step(0, 1, 7, 0);
        mid_reset();
        step(1, 1, 2, 0);
        repeat (8) step(0, 1, 2, 0);

        cdiv = 4;
        cinv = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                mid_reset();
                step(1, 1, cdiv, cinv);
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    cdiv = ($urandom_range(0, 7) == 0)
                         ? int'($urandom_range(0, 40))
                         : int'($urandom_range(0, 9));
                end
                if ($urandom_range(0, 11) == 0) cinv = ~cinv;
                step(0, $urandom_range(0, 15) != 0, cdiv, cinv);
            end
        end

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
